// File: rtl/dtcm_arbiter_pkg.sv
// Shared encodings for the DTCM arbiter slice.
// Requester ids, FSM states and the full-word byte strobe.
package dtcm_arbiter_pkg;

    typedef enum logic [1:0] {
        RID_NONE  = 2'd0,
        RID_DATA  = 2'd1,
        RID_INSTR = 2'd2,
        RID_DMA   = 2'd3
    } rid_e;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam logic [3:0] STRB_FULL = 4'hF;

endpackage

// File: rtl/dtcm_arbiter_if.sv
// DTCM bus bundle: three requester ports plus the SRAM port.
// Modports: slave = arbiter side, master = requesters/memory side.
interface dtcm_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    data_req;
    logic                    data_ready;
    logic                    data_rd0_wr1;
    logic [3:0]              data_byte_strobe;
    logic [ADDR_WIDTH-1:0]   data_addr;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic [DATA_WIDTH-1:0]   data_rdata;
    logic                    data_rdata_valid;

    logic                    instr_req;
    logic                    instr_ready;
    logic [ADDR_WIDTH-1:0]   instr_addr;
    logic [DATA_WIDTH-1:0]   instr_rdata;
    logic                    instr_rdata_valid;

    logic                    dma_req;
    logic                    dma_ready;
    logic                    dma_rd0_wr1;
    logic [ADDR_WIDTH-1:0]   dma_addr;
    logic [DATA_WIDTH-1:0]   dma_wdata;
    logic [DATA_WIDTH-1:0]   dma_rdata;
    logic                    dma_rdata_valid;
    logic                    dma_lock;

    logic                    mem_en;
    logic                    mem_wen;
    logic [3:0]              mem_byte_strobe;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  data_req, data_rd0_wr1, data_byte_strobe, data_addr, data_wdata,
        output data_ready, data_rdata, data_rdata_valid,
        input  instr_req, instr_addr,
        output instr_ready, instr_rdata, instr_rdata_valid,
        input  dma_req, dma_rd0_wr1, dma_addr, dma_wdata, dma_lock,
        output dma_ready, dma_rdata, dma_rdata_valid,
        output mem_en, mem_wen, mem_byte_strobe, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output data_req, data_rd0_wr1, data_byte_strobe, data_addr, data_wdata,
        input  data_ready, data_rdata, data_rdata_valid,
        output instr_req, instr_addr,
        input  instr_ready, instr_rdata, instr_rdata_valid,
        output dma_req, dma_rd0_wr1, dma_addr, dma_wdata, dma_lock,
        input  dma_ready, dma_rdata, dma_rdata_valid,
        input  mem_en, mem_wen, mem_byte_strobe, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dtcm_arb_starve_cnt.sv
// Saturating wait counter for one core port with a limit compare.
// Ports: clk, rstn, req, grant, freeze in; starving out.
module dtcm_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic req,
    input  logic grant,
    input  logic freeze,
    output logic starving
);
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 4'd0;
        end else if (!freeze) begin
            if (!req || grant) begin
                cnt <= 4'd0;
            end else if (cnt != 4'hF) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign starving = (cnt >= 4'(LIMIT));
endmodule

// File: rtl/dtcm_arbiter.sv
// Single-port DTCM arbiter: DMA > data > instr, DMA lock, read return.
// Ports: clk, rstn, bus (slave). Optional guard: DTCM_ARB_STARVE_EN.
module dtcm_arbiter
    import dtcm_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rstn,
    dtcm_arbiter_if.slave bus
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_lim_chk
        $error("STARVE_LIMIT out of range 1..15");
    end

    state_e state, state_nxt;
    rid_e   rd_id;
    logic   g_data, g_instr, g_dma;
    logic   starve_data, starve_instr;

    logic [ADDR_WIDTH-1:0] addr_q, addr_mux;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_mux;
    logic [3:0]            strb_q, strb_mux;
    logic                  wen_mux;

`ifdef DTCM_ARB_STARVE_EN
    logic lock_st;
    assign lock_st = (state == ST_LOCK);

    dtcm_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_cnt_data (
        .clk      (clk),
        .rstn     (rstn),
        .req      (bus.data_req),
        .grant    (g_data),
        .freeze   (lock_st),
        .starving (starve_data)
    );

    dtcm_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_cnt_instr (
        .clk      (clk),
        .rstn     (rstn),
        .req      (bus.instr_req),
        .grant    (g_instr),
        .freeze   (lock_st),
        .starving (starve_instr)
    );
`else
    assign starve_data  = 1'b0;
    assign starve_instr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_ARB;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        g_data    = 1'b0;
        g_instr   = 1'b0;
        g_dma     = 1'b0;
        unique case (state)
            ST_ARB: begin
                // A starving core port jumps ahead of the DMA.
                if (starve_data && bus.data_req)        g_data  = 1'b1;
                else if (starve_instr && bus.instr_req) g_instr = 1'b1;
                else if (bus.dma_req)                   g_dma   = 1'b1;
                else if (bus.data_req)                  g_data  = 1'b1;
                else if (bus.instr_req)                 g_instr = 1'b1;
                if (g_dma && bus.dma_lock) state_nxt = ST_LOCK;
            end
            ST_LOCK: begin
                g_dma = bus.dma_req;
                if (!bus.dma_lock) state_nxt = ST_ARB;
            end
        endcase
    end

    // Without a grant the memory address/data/strobe hold their last values.
    always_comb begin
        addr_mux  = addr_q;
        wdata_mux = wdata_q;
        strb_mux  = strb_q;
        wen_mux   = 1'b0;
        unique case (1'b1)
            g_dma: begin
                addr_mux  = bus.dma_addr;
                wdata_mux = bus.dma_wdata;
                strb_mux  = STRB_FULL;
                wen_mux   = bus.dma_rd0_wr1;
            end
            g_data: begin
                addr_mux  = bus.data_addr;
                wdata_mux = bus.data_wdata;
                strb_mux  = bus.data_byte_strobe;
                wen_mux   = bus.data_rd0_wr1;
            end
            g_instr: begin
                addr_mux  = bus.instr_addr;
                strb_mux  = STRB_FULL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            addr_q  <= addr_mux;
            wdata_q <= wdata_mux;
            strb_q  <= strb_mux;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                           rd_id <= RID_NONE;
        else if (g_dma && !bus.dma_rd0_wr1)  rd_id <= RID_DMA;
        else if (g_data && !bus.data_rd0_wr1) rd_id <= RID_DATA;
        else if (g_instr)                    rd_id <= RID_INSTR;
        else                                 rd_id <= RID_NONE;
    end

    assign bus.data_ready  = g_data;
    assign bus.instr_ready = g_instr;
    assign bus.dma_ready   = g_dma;

    assign bus.mem_en          = g_data | g_instr | g_dma;
    assign bus.mem_wen         = wen_mux;
    assign bus.mem_addr        = addr_mux;
    assign bus.mem_wdata       = wdata_mux;
    assign bus.mem_byte_strobe = strb_mux;

    assign bus.data_rdata  = bus.mem_rdata;
    assign bus.instr_rdata = bus.mem_rdata;
    assign bus.dma_rdata   = bus.mem_rdata;

    assign bus.data_rdata_valid  = (rd_id == RID_DATA);
    assign bus.instr_rdata_valid = (rd_id == RID_INSTR);
    assign bus.dma_rdata_valid   = (rd_id == RID_DMA);
endmodule

// File: tb/tb_dtcm_arbiter.sv
// Self-checking bench for dtcm_arbiter with a behavioural SRAM.
// Directed sequences, a vector table and a randomized model run.
module tb_dtcm_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dtcm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    dtcm_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] sram [0:255];
    logic [31:0] shadow [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_we) sram[pre_idx] <= pre_val;
        else if (bus.mem_en && bus.mem_wen)
            for (int b = 0; b < 4; b++)
                if (bus.mem_byte_strobe[b])
                    sram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) bus.mem_rdata <= '0;
        else if (bus.mem_en && !bus.mem_wen)
            bus.mem_rdata <= sram[bus.mem_addr[9:2]];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] grants();
        return {bus.dma_ready, bus.data_ready, bus.instr_ready};
    endfunction

    function automatic logic [2:0] valids();
        return {bus.dma_rdata_valid, bus.data_rdata_valid, bus.instr_rdata_valid};
    endfunction

    task automatic idle();
        bus.data_req = 0; bus.data_rd0_wr1 = 0; bus.data_byte_strobe = 4'hF;
        bus.data_addr = '0; bus.data_wdata = '0;
        bus.instr_req = 0; bus.instr_addr = '0;
        bus.dma_req = 0; bus.dma_rd0_wr1 = 0; bus.dma_addr = '0;
        bus.dma_wdata = '0; bus.dma_lock = 0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, " ready"}, 64'(grants()), 0);
        chk({nm, " valid"}, 64'(valids()), 0);
        chk({nm, " mem_en/wen/strb"},
            {59'd0, bus.mem_en, bus.mem_wen, bus.mem_byte_strobe}, 0);
        chk({nm, " mem_addr"}, 64'(bus.mem_addr), 0);
        chk({nm, " mem_wdata"}, 64'(bus.mem_wdata), 0);
        chk({nm, " rdata"},
            {bus.data_rdata ^ bus.instr_rdata, bus.dma_rdata}, 0);
    endtask

    typedef struct {
        logic       d, i, m, lk;
        logic [2:0] g;
    } vec_t;

    vec_t vt[16];
    logic [2:0] exp_g, prev_g;

    // random-phase model state
    bit          locked;
    int          wait_d, wait_i, lock_left, win, exp_rid;
    logic [31:0] exp_rdata, last_addr;
    logic [3:0]  last_strb;
    bit          d_hold, i_hold, m_hold;
    bit          d_req, d_wr, i_req, m_req, m_wr;
    logic [3:0]  d_strb;
    logic [31:0] d_addr, d_wd, i_addr, m_addr, m_wd, a_w;
    logic [3:0]  s_w;
    logic [31:0] wd_w;
    bit          wr_w;

    initial begin
        idle();
        rstn = 0;
        repeat (2) @(negedge clk);
        #1 chk_reset_outs("reset");

        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            pre_we = 1; pre_idx = 8'(k);
            pre_val = (k == 64) ? 32'hDEADBEEF :
                      (k == 16) ? 32'hFFFFFFFF : $urandom;
            shadow[k] = pre_val;
        end
        @(negedge clk);
        pre_we = 0;
        rstn = 1;

        // single data read
        @(negedge clk);
        bus.data_req = 1; bus.data_addr = 32'h100;
        #1;
        chk("rd ready", 64'(grants()), 3'b010);
        chk("rd mem_addr", 64'(bus.mem_addr), 32'h100);
        chk("rd en/wen", {62'd0, bus.mem_en, bus.mem_wen}, 2'b10);
        @(negedge clk);
        bus.data_req = 0;
        #1;
        chk("rd valid", 64'(valids()), 3'b010);
        chk("rd data", 64'(bus.data_rdata), 32'hDEADBEEF);
        @(negedge clk);
        #1 chk("rd valid drop", 64'(valids()), 0);

        // three simultaneous reads
        @(negedge clk);
        bus.dma_req = 1; bus.dma_addr = 32'h30;
        bus.data_req = 1; bus.data_addr = 32'h20;
        bus.instr_req = 1; bus.instr_addr = 32'h10;
        #1 chk("3rd g1", 64'(grants()), 3'b100);
        @(negedge clk);
        bus.dma_req = 0;
        #1;
        chk("3rd g2", 64'(grants()), 3'b010);
        chk("3rd v1", 64'(valids()), 3'b100);
        chk("3rd dma data", 64'(bus.dma_rdata), 64'(shadow[12]));
        @(negedge clk);
        bus.data_req = 0;
        #1;
        chk("3rd g3", 64'(grants()), 3'b001);
        chk("3rd v2", 64'(valids()), 3'b010);
        chk("3rd data data", 64'(bus.data_rdata), 64'(shadow[8]));
        @(negedge clk);
        bus.instr_req = 0;
        #1;
        chk("3rd g4", 64'(grants()), 0);
        chk("3rd v3", 64'(valids()), 3'b001);
        chk("3rd instr data", 64'(bus.instr_rdata), 64'(shadow[4]));

        // partial write then read back
        @(negedge clk);
        bus.data_req = 1; bus.data_rd0_wr1 = 1; bus.data_addr = 32'h40;
        bus.data_byte_strobe = 4'b0011; bus.data_wdata = 32'h11223344;
        #1;
        chk("wr ready", 64'(grants()), 3'b010);
        chk("wr wen/strb", {59'd0, bus.mem_wen, bus.mem_byte_strobe}, 5'b10011);
        @(negedge clk);
        bus.data_rd0_wr1 = 0; bus.data_byte_strobe = 4'hF;
        #1 chk("wr no valid", 64'(valids()), 0);
        @(negedge clk);
        bus.data_req = 0;
        #1;
        chk("wr rb valid", 64'(valids()), 3'b010);
        chk("wr rb data", 64'(bus.data_rdata), 32'hFFFF3344);
        shadow[16] = 32'hFFFF3344;

        // dma lock for 6 cycles
        @(negedge clk);
        bus.dma_req = 1; bus.dma_lock = 1; bus.dma_addr = 32'h44;
        bus.data_req = 1; bus.data_addr = 32'h48;
        for (int k = 0; k < 6; k++) begin
            #1 chk("lock hold", 64'(grants()), 3'b100);
            @(negedge clk);
        end
        bus.dma_req = 0; bus.dma_lock = 0;
        #1 chk("lock exit cyc", 64'(grants()), 0);
        @(negedge clk);
        #1 chk("lock after", 64'(grants()), 3'b010);
        @(negedge clk);
        bus.data_req = 0;

        // starvation against continuous dma
        @(negedge clk);
        bus.dma_req = 1; bus.data_req = 1;
        for (int k = 1; k <= 6; k++) begin
            #1;
`ifdef DTCM_ARB_STARVE_EN
            exp_g = (k == LIM + 1) ? 3'b010 : 3'b100;
`else
            exp_g = 3'b100;
`endif
            chk("starve", 64'(grants()), 64'(exp_g));
            @(negedge clk);
            if (exp_g == 3'b010) bus.data_req = 0;
        end
        idle();

        // reset right after an instr read grant
        @(negedge clk);
        bus.instr_req = 1; bus.instr_addr = 32'h8;
        #1 chk("rst instr g", 64'(grants()), 3'b001);
        @(negedge clk);
        rstn = 0; bus.instr_req = 0;
        #1 chk_reset_outs("midrst");
        @(negedge clk);
        rstn = 1;
        bus.dma_req = 1; bus.dma_lock = 1;
        #1;
        chk("rst no valid", 64'(valids()), 0);
        chk("rst lock g", 64'(grants()), 3'b100);
        @(negedge clk);
        bus.dma_req = 0; rstn = 0;
        @(negedge clk);
        rstn = 1; bus.data_req = 1; bus.data_addr = 32'h4;
        #1 chk("rst exits lock", 64'(grants()), 3'b010);
        @(negedge clk);
        idle();

        // vector table, all reads
        vt[0]  = '{1,0,0,0, 3'b010};
        vt[1]  = '{0,1,0,0, 3'b001};
        vt[2]  = '{1,1,0,0, 3'b010};
        vt[3]  = '{0,1,0,0, 3'b001};
        vt[4]  = '{0,0,1,0, 3'b100};
        vt[5]  = '{0,1,1,0, 3'b100};
        vt[6]  = '{1,1,0,0, 3'b010};
        vt[7]  = '{0,1,0,0, 3'b001};
        vt[8]  = '{0,0,0,1, 3'b000};
        vt[9]  = '{1,0,0,1, 3'b010};
        vt[10] = '{0,0,1,1, 3'b100};
        vt[11] = '{1,1,0,1, 3'b000};
        vt[12] = '{1,1,1,0, 3'b100};
        vt[13] = '{1,1,0,0, 3'b010};
        vt[14] = '{0,1,0,0, 3'b001};
        vt[15] = '{0,0,0,0, 3'b000};
        @(negedge clk);
        prev_g = 3'b000;
        foreach (vt[k]) begin
            bus.data_req = vt[k].d; bus.instr_req = vt[k].i;
            bus.dma_req = vt[k].m; bus.dma_lock = vt[k].lk;
            #1;
            chk($sformatf("vec%0d grant", k), 64'(grants()), 64'(vt[k].g));
            chk($sformatf("vec%0d en", k), 64'(bus.mem_en), 64'(|vt[k].g));
            chk($sformatf("vec%0d valid", k), 64'(valids()), 64'(prev_g));
            prev_g = vt[k].g;
            @(negedge clk);
        end
        idle();

        // randomized run against the reference model
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        locked = 0; wait_d = 0; wait_i = 0; lock_left = 0;
        exp_rid = 0; exp_rdata = '0; last_addr = '0; last_strb = '0;
        d_hold = 0; i_hold = 0; m_hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!d_hold) begin
                d_req = ($urandom_range(0, 99) < 50);
                d_wr = 1'($urandom_range(0, 1));
                d_strb = 4'($urandom_range(1, 15));
                d_addr = {$urandom_range(0, 31), 2'b00};
                d_wd = $urandom;
            end
            if (!i_hold) begin
                i_req = ($urandom_range(0, 99) < 50);
                i_addr = {$urandom_range(0, 31), 2'b00};
            end
            if (!m_hold) begin
                m_req = ($urandom_range(0, 99) < 40);
                m_wr = 1'($urandom_range(0, 1));
                m_addr = {$urandom_range(0, 31), 2'b00};
                m_wd = $urandom;
            end
            if (lock_left == 0 && $urandom_range(0, 99) < 10)
                lock_left = $urandom_range(1, 6);
            bus.data_req = d_req; bus.data_rd0_wr1 = d_wr;
            bus.data_byte_strobe = d_strb; bus.data_addr = d_addr;
            bus.data_wdata = d_wd;
            bus.instr_req = i_req; bus.instr_addr = i_addr;
            bus.dma_req = m_req; bus.dma_rd0_wr1 = m_wr;
            bus.dma_addr = m_addr; bus.dma_wdata = m_wd;
            bus.dma_lock = (lock_left > 0);
            #1;

            // 0 none, 1 data, 2 instr, 3 dma
            win = 0;
            if (locked) begin
                if (m_req) win = 3;
            end else begin
`ifdef DTCM_ARB_STARVE_EN
                if (d_req && wait_d >= LIM) win = 1;
                else if (i_req && wait_i >= LIM) win = 2;
`endif
                if (win == 0) begin
                    if (m_req) win = 3;
                    else if (d_req) win = 1;
                    else if (i_req) win = 2;
                end
            end

            exp_g = (win == 3) ? 3'b100 : (win == 1) ? 3'b010 :
                    (win == 2) ? 3'b001 : 3'b000;
            chk("rnd grant", 64'(grants()), 64'(exp_g));
            chk("rnd en", 64'(bus.mem_en), 64'(win != 0));
            chk("rnd valid", 64'(valids()),
                64'((exp_rid == 3) ? 3'b100 : (exp_rid == 1) ? 3'b010 :
                    (exp_rid == 2) ? 3'b001 : 3'b000));
            if (exp_rid != 0)
                chk("rnd rdata", 64'(bus.mem_rdata), 64'(exp_rdata));

            a_w = last_addr; s_w = last_strb; wr_w = 0; wd_w = '0;
            if (win == 1) begin a_w = d_addr; s_w = d_strb; wr_w = d_wr; wd_w = d_wd; end
            if (win == 2) begin a_w = i_addr; s_w = 4'hF; end
            if (win == 3) begin a_w = m_addr; s_w = 4'hF; wr_w = m_wr; wd_w = m_wd; end
            chk("rnd addr", 64'(bus.mem_addr), 64'(a_w));
            chk("rnd strb", 64'(bus.mem_byte_strobe), 64'(s_w));
            chk("rnd wen", 64'(bus.mem_wen), 64'(wr_w));
            if (win == 1 || win == 3)
                chk("rnd wdata", 64'(bus.mem_wdata), 64'(wd_w));
            last_addr = a_w; last_strb = s_w;

            exp_rid = (win != 0 && !wr_w) ? win : 0;
            if (exp_rid != 0) exp_rdata = shadow[a_w[9:2]];
            if (wr_w)
                for (int b = 0; b < 4; b++)
                    if (s_w[b]) shadow[a_w[9:2]][8*b +: 8] = wd_w[8*b +: 8];

            if (!locked) begin
                wait_d = (d_req && win != 1) ? ((wait_d < 15) ? wait_d + 1 : 15) : 0;
                wait_i = (i_req && win != 2) ? ((wait_i < 15) ? wait_i + 1 : 15) : 0;
            end
            if (locked) locked = (lock_left > 0);
            else        locked = (win == 3) && (lock_left > 0);
            d_hold = d_req && (win != 1);
            i_hold = i_req && (win != 2);
            m_hold = m_req && (win != 3);
            if (lock_left > 0) lock_left--;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dtcm_arbiter.md
# dtcm_arbiter

Single-port arbiter and sequencer for the data TCM. It sits between the three DTCM requesters (core data interface, core instruction interface, DMA) and one single-ported synchronous SRAM. Each cycle it grants exactly one requester, drives the memory port, and routes the one-cycle-latency read data back with a per-requester valid. A DMA lock state and an optional starvation guard give bounded latency to the core ports.

## Interface
Parameters:
- ADDR_WIDTH, 32, requester/memory byte-address width
- DATA_WIDTH, 32, data width (byte strobes are DATA_WIDTH/8 = 4 bits)
- STARVE_LIMIT, 4, consecutive denied cycles before forced grant (legal range 1..15)

Ports (x ∈ {data, instr, dma}):
- clk  in  1  clock
- rstn  in  1  reset; asynchronous assert, active-low
- x_req  in  1  access request
- x_ready  out  1  request accepted this cycle (combinational)
- data_rd0_wr1, dma_rd0_wr1  in  1  0 = read, 1 = write (instr is read-only)
- data_byte_strobe  in  4  write byte enables (DMA writes are always 4'hF)
- x_addr  in  ADDR_WIDTH  byte address
- data_wdata, dma_wdata  in  DATA_WIDTH  write data
- x_rdata  out  DATA_WIDTH  read data (all three driven from mem_rdata)
- x_rdata_valid  out  1  read data valid for x
- dma_lock  in  1  DMA holds the port while high
- mem_en  out  1  memory access enable
- mem_wen  out  1  memory write enable
- mem_byte_strobe  out  4  memory byte enables
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_en with mem_wen=0

## Operation
- Default priority: DMA > data > instr. Grant is a one-hot combinational function of the requests, current state and starvation counters.
- x_ready = grant_x. A request that is not granted must be held stable by the requester until ready.
- Memory port muxing:
  - Granted requester drives mem_addr, mem_wdata and mem_byte_strobe.
  - Instruction reads and DMA transfers use strobe 4'hF.
  - mem_en = any grant.
  - mem_wen = grant & rd0_wr1 of the granted requester.
- No grant: mem_en = 0. mem_addr, mem_wdata and mem_byte_strobe hold their last values; no toggle required.
- State machine:
  - ARB: normal arbitration. Go to LOCK when the DMA is granted and dma_lock = 1.
  - LOCK: only the DMA can be granted; data and instr are denied. Return to ARB in the cycle after dma_lock falls. A DMA request in the same cycle that dma_lock falls is still granted.
- Read return pipeline:
  - Register rd_id (2 bits: none/data/instr/dma). It is set on a granted read, otherwise none.
  - x_rdata_valid = (rd_id == x). Writes never produce a valid.
- Starvation guard (macro enabled):
  - Per-core-port 4-bit counter: increments when x_req is high and not granted, clears on grant or when x_req is low, saturates at 15.
  - When a counter ≥ STARVE_LIMIT in ARB, that port gets top priority. Data wins if both ports are starving.
  - Does not apply in LOCK. Counters freeze in LOCK.

## Timing
- Reset values:
  - All x_ready = 0 (no requests during reset) and all x_rdata_valid = 0.
  - mem_en = 0, mem_wen = 0, mem_byte_strobe = 0, mem_addr = 0, mem_wdata = 0, x_rdata = 0.
  - State = ARB, counters = 0, rd_id = none.
- Latency:
  - Grant is in the same cycle as the request when no conflict.
  - Read data arrives with x_rdata_valid in cycle N+1 after acceptance in cycle N.
  - A write completes at the clock edge ending cycle N.
- Back-to-back accesses from any mix of requesters run every cycle, 1 per cycle throughput.
- Write then read to the same address in consecutive cycles returns the new data; no forwarding is needed because the SRAM is sequential.
- Reset asserted mid-operation:
  - An outstanding rd_id is dropped; no valid is produced after reset release.
  - LOCK is exited.
- dma_lock high with no DMA request in ARB has no effect.

## Configuration
- DTCM_ARB_STARVE_EN defined: the starvation counters and forced-priority logic are compiled in. Worst-case data-port wait in ARB is STARVE_LIMIT cycles.
- Not defined: pure fixed priority DMA > data > instr. No counters are instantiated, and STARVE_LIMIT is unused.

## Structure
- Shared package holds:
  - requester-id encoding constants (RID_NONE = 0, RID_DATA = 1, RID_INSTR = 2, RID_DMA = 3)
  - state encoding (ST_ARB, ST_LOCK)
  - full-word strobe constant 4'hF
- One sub-module: dtcm_arb_starve_cnt (a single saturating counter with a limit compare), instantiated once per core port under the macro.
- The memory array itself stays outside this block.

## Test plan
- Single data read of 0x100 with the memory preloaded to 0xDEADBEEF → data_ready high the same cycle, mem_addr = 0x100, data_rdata_valid next cycle with 0xDEADBEEF; other valids stay 0.
- data, instr and dma all request reads in the same cycle → dma granted first, then data, then instr, one per cycle; each valid one cycle after its own grant.
- Data write 0x11223344 with strobe 4'b0011 to 0x40 over 0xFFFFFFFF, then read 0x40 → 0xFFFF3344.
- dma_lock high for 6 cycles while data requests continuously → data denied for all 6 cycles; data granted the cycle after lock drops and the DMA stops requesting.
- Macro on, STARVE_LIMIT = 4, continuous DMA requests without lock plus a data request → data granted on the 5th cycle. Macro off → data is never granted while the DMA requests.
- Reset asserted the cycle after a granted instr read → instr_rdata_valid stays 0, all outputs at their reset values, state ARB on release.
